wait_counter: RTL
=================

Name: wait_counter

Overview:
- Timer stage directly downstream of the thermostat control FSM.
- Consumes the FSM's wait-counter request: ID_WC selects a duration, CLR_WC restarts timing, RUN gates timing.
- Returns T_WC, the elapsed flag, to the FSM.
- Holds a prescaler plus a saturating tick counter, so the FSM never counts raw clocks.

Parameters:
- PRESC_DIV, 100, clock cycles per timer tick; must be >= 1.
- CNT_W, 16, width of the tick counter and of the limits.
- T_ID0, 5, limit in ticks for ID_WC=0.
- T_ID1, 10, limit in ticks for ID_WC=1.
- T_ID2, 30, limit in ticks for ID_WC=2.
- T_ID3, 60, limit in ticks for ID_WC=3.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- RUN  in  1  global enable; when 0, the prescaler and counter freeze.
- ID_WC  in  2  duration select from the FSM.
- CLR_WC  in  1  synchronous clear/restart request from the FSM.
- T_WC  out  1  registered flag: the selected duration has elapsed; sticky until cleared.
- CNT  out  CNT_W  current elapsed tick count, registered.
- TICK  out  1  registered single-cycle pulse on each prescaler wrap; debug only.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, pre=0, CNT=0, T_WC=0, TICK=0. Reset mid-count discards all progress.
- Limit: lim = T_ID[ID_WC], decoded combinationally every cycle, zero-extended to CNT_W.
- Prescaler: pre counts 0..PRESC_DIV-1, only in COUNT with RUN=1.
  - tick = COUNT & RUN & (pre==PRESC_DIV-1); pre wraps to 0 on tick.
  - TICK<=tick.
  - With PRESC_DIV=1, tick fires every enabled COUNT cycle.
- FSM states:
  - IDLE: CNT=0, pre=0, T_WC=0. Goes to COUNT when CLR_WC=0 & RUN=1.
  - COUNT:
    - On tick, CNT<=CNT+1.
    - If (tick & CNT+1>=lim) or (CNT>=lim), go to DONE and set T_WC<=1 on the same edge.
  - DONE: CNT and T_WC=1 held. ID_WC and RUN changes are ignored. Leaves only on CLR_WC.
- CLR_WC=1 in any state:
  - Next edge gives IDLE, CNT=0, pre=0, T_WC=0.
  - Clear beats a simultaneous tick or DONE transition.
  - CLR_WC held high keeps the block in IDLE.
- RUN=0 in COUNT: pre and CNT freeze and the state stays COUNT. Counting resumes where it left off.
- ID_WC change during COUNT: the new lim applies immediately. If CNT>=new lim, go to DONE on the next edge, without a tick.
- lim=0: COUNT goes to DONE on the first COUNT edge, so T_WC rises 2 edges after the clear is released.
- Latency, lim=L>=1, RUN held 1:
  - T_WC rises exactly 1+L*PRESC_DIV rising edges after the first edge that samples CLR_WC=0.
  - That count includes the IDLE->COUNT edge.
- Saturation: CNT never exceeds lim and never wraps.
- Limits >= 2^CNT_W are an elaboration error, enforced by a generate-time check.

Decomposition:
- Shared package thermo_pkg holds:
  - the ID_WC encodings (WC_ID_0..WC_ID_3);
  - the 2-bit state encoding (ST_IDLE=0, ST_COUNT=1, ST_DONE=2).
- The FSM and this block both import it.
- Natural sub-module: wc_prescaler.
  - Inputs: clk, rst_n, en, clr.
  - Output: tick.
  - Parameter: PRESC_DIV.
- The state machine and counter stay in wait_counter.

Test Plan (all with PRESC_DIV=4, T_ID0=2, T_ID1=3, T_ID2=5, T_ID3=0, CNT_W=8):
1. Reset: rst_n=0 asserted mid-count (CNT=1) -> CNT=0, T_WC=0, TICK=0 immediately, with no clock edge needed; state IDLE after release.
2. Basic timing: ID_WC=1, RUN=1, CLR_WC pulsed then released -> T_WC rises on edge 13 (1+3*4) after release; TICK pulses on edges 5, 9, 13; CNT ends at 3 and holds.
3. Freeze: ID_WC=0, RUN dropped for 7 cycles after the first tick -> CNT stays 1 during the gap; T_WC rises exactly 7 edges later than the no-gap edge 9, i.e. on edge 16.
4. ID change: ID_WC=2 counting with CNT=3, then ID_WC switched to 0 -> DONE and T_WC=1 on the next edge with no tick; a later switch back to 2 leaves T_WC=1.
5. Clear priority: CLR_WC=1 on the same cycle as the tick that would reach the limit -> T_WC stays 0, CNT=0; restarting with ID_WC=3 (limit 0) -> T_WC=1 two edges after release.

Source files
------------

// File: rtl/thermo_pkg.sv
// Shared definitions between the thermostat control FSM and its wait counter.
// Holds the ID_WC duration encodings, the wait-counter state encoding and a
// helper used to validate limit parameters at elaboration.
package thermo_pkg;

  // Duration select encodings driven on ID_WC
  localparam logic [1:0] WC_ID_0 = 2'd0;
  localparam logic [1:0] WC_ID_1 = 2'd1;
  localparam logic [1:0] WC_ID_2 = 2'd2;
  localparam logic [1:0] WC_ID_3 = 2'd3;

  // Wait-counter state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } wc_state_e;

  // True when value v is representable in w bits
  function automatic bit lim_fits(input longint unsigned v, input int unsigned w);
    return (v >> w) == 64'd0;
  endfunction

endpackage

// File: rtl/wc_prescaler.sv
// Clock prescaler for the wait counter: emits one tick every PRESC_DIV
// enabled cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance the prescaler this cycle
//   clr        : restart from zero; suppresses any tick this cycle
//   tick       : combinational wrap pulse (pre == PRESC_DIV-1 while enabled)
module wc_prescaler #(
  parameter int unsigned PRESC_DIV = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PRE_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESC_DIV - 1);

  logic [PRE_W-1:0] pre_q;

  // Clear wins over a coincident wrap
  assign tick = en & ~clr & (pre_q == PRE_MAX);

  // Prescaler register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else if (clr || tick) begin
      pre_q <= '0;
    end else if (en) begin
      pre_q <= pre_q + PRE_W'(1);
    end
  end

endmodule

// File: rtl/wait_counter.sv
// Wait-counter timer for the thermostat FSM. Counts prescaled ticks up to the
// limit selected by ID_WC and raises the sticky T_WC flag when reached.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   RUN        : global enable; freezes prescaler and counter when low
//   ID_WC      : duration select
//   CLR_WC     : synchronous clear/restart, highest priority
//   T_WC       : registered elapsed flag, sticky until cleared
//   CNT        : registered elapsed tick count
//   TICK       : registered prescaler wrap pulse (debug)
module wait_counter
  import thermo_pkg::*;
#(
  parameter int unsigned PRESC_DIV = 100,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned T_ID0     = 5,
  parameter int unsigned T_ID1     = 10,
  parameter int unsigned T_ID2     = 30,
  parameter int unsigned T_ID3     = 60
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RUN,
  input  logic [1:0]       ID_WC,
  input  logic             CLR_WC,
  output logic             T_WC,
  output logic [CNT_W-1:0] CNT,
  output logic             TICK
);

  // Elaboration-time parameter checks
  if (PRESC_DIV < 1) begin : g_bad_presc
    $error("wait_counter: PRESC_DIV must be >= 1");
  end
  if (!lim_fits(longint'(T_ID0), CNT_W) || !lim_fits(longint'(T_ID1), CNT_W) ||
      !lim_fits(longint'(T_ID2), CNT_W) || !lim_fits(longint'(T_ID3), CNT_W)) begin : g_bad_lim
    $error("wait_counter: a T_ID limit does not fit in CNT_W bits");
  end

  wc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             t_wc_q, t_wc_d;
  logic             tick_q;
  logic [CNT_W-1:0] lim;
  logic [CNT_W-1:0] cnt_inc;
  logic             tick;
  logic             pre_en;
  logic             pre_clr;

  // Limit decode, re-evaluated every cycle so ID_WC changes apply at once
  always_comb begin
    lim = CNT_W'(T_ID0);
    case (ID_WC)
      WC_ID_0: lim = CNT_W'(T_ID0);
      WC_ID_1: lim = CNT_W'(T_ID1);
      WC_ID_2: lim = CNT_W'(T_ID2);
      WC_ID_3: lim = CNT_W'(T_ID3);
      default: lim = CNT_W'(T_ID0);
    endcase
  end

  // Prescaler only runs in COUNT; held at zero everywhere else
  assign pre_en  = (state_q == ST_COUNT) & RUN;
  assign pre_clr = CLR_WC | (state_q != ST_COUNT);

  wc_prescaler #(
    .PRESC_DIV (PRESC_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pre_en),
    .clr   (pre_clr),
    .tick  (tick)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  // State register and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      t_wc_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_wc_q  <= t_wc_d;
      tick_q  <= tick;
    end
  end

  // Next-state logic; clear overrides every transition
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_wc_d  = t_wc_q;
    if (CLR_WC) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      t_wc_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d  = '0;
          t_wc_d = 1'b0;
          if (RUN) begin
            state_d = ST_COUNT;
          end
        end
        ST_COUNT: begin
          // Increment only below the limit so CNT saturates
          if (tick && (cnt_q < lim)) begin
            cnt_d = cnt_inc;
          end
          if ((tick && (cnt_inc >= lim)) || (cnt_q >= lim)) begin
            state_d = ST_DONE;
            t_wc_d  = 1'b1;
          end
        end
        ST_DONE: begin
          t_wc_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          t_wc_d  = 1'b0;
        end
      endcase
    end
  end

  assign T_WC = t_wc_q;
  assign CNT  = cnt_q;
  assign TICK = tick_q;

endmodule
